wb_master_cmd_bridge: RTL and testbench
=======================================

Name: wb_master_cmd_bridge

Overview:
Synthesizable Wishbone B4 pipelined master that converts a valid/ready command stream into WB transfers for the memory-mapped slave stage directly downstream. Tracks up to MAX_OUTSTANDING in-flight addresses, honours STALL, and returns one response per accepted command. Sits between CPU/DMA request logic and the WB slave. Flushes on a response timeout.

Parameters:
MAX_OUTSTANDING, 4, maximum accepted-but-unacknowledged addresses (power of 2, 1..16).
TIMEOUT_CYCLES, 255, cycles with outstanding>0 and no ACK/ERR before abort (1..65535).

Ports:
CLK  input  1  clock; all logic on posedge.
RST_ASYNC_N  input  1  asynchronous active-low reset.
CMD_VALID_IN  input  1  command present.
CMD_READY_OUT  output  1  command accepted when VALID&READY.
CMD_ADR_IN  input  32  byte address.
CMD_WE_IN  input  1  1 = write, 0 = read.
CMD_SEL_IN  input  4  byte lanes.
CMD_DAT_IN  input  32  write data.
CMD_LAST_IN  input  1  final command of this WB cycle.
RSP_VALID_OUT  output  1  one-cycle response pulse; consumer must always accept.
RSP_DAT_OUT  output  32  read data (0 for writes).
RSP_WE_OUT  output  1  type of the command being responded to.
RSP_ERR_OUT  output  1  slave returned ERR.
TIMEOUT_OUT  output  1  one-cycle pulse on timeout abort.
WB_ADR_OUT / WB_WE_OUT / WB_SEL_OUT / WB_DAT_WR_OUT  output  32/1/4/32  registered address-phase fields.
WB_CYC_OUT, WB_STB_OUT  output  1 each.
WB_CTI_OUT  output  3  3'b010 incrementing, 3'b111 on LAST beat.
WB_BTE_OUT  output  2  constant 2'b00.
WB_STALL_IN, WB_ACK_IN, WB_ERR_IN  input  1 each.
WB_DAT_RD_IN  input  32  read data, valid with ACK.

Behaviour:
- Reset (async assert, sync release): all outputs 0, counters 0, FIFO empty, state IDLE.
- States: IDLE, ACTIVE (CYC=1, accepting), DRAIN (LAST issued, waiting responses).
- CMD_READY_OUT = (state!=DRAIN) & (~WB_STB_OUT | ~WB_STALL_IN) & (outstanding + STB held < MAX_OUTSTANDING); combinational.
- Accept: registers fields onto WB_*; STB=1, CYC=1 next cycle (zero-bubble issue). IDLE->ACTIVE; if CMD_LAST_IN, ->DRAIN after the beat is taken.
- While STB & STALL: all address-phase outputs held stable. Beat taken on STB & ~STALL; STB drops next cycle unless a new command accepted same cycle.
- Outstanding counter: +1 on beat taken, -1 on ACK|ERR; both same cycle -> unchanged. Never exceeds MAX_OUTSTANDING.
- WE FIFO (depth MAX_OUTSTANDING): push WE on beat taken, pop on ACK|ERR; push+pop same cycle legal at any fill.
- Response: registered, 1 cycle after ACK|ERR. RSP_DAT_OUT = WB_DAT_RD_IN if read & ACK, else 0. RSP_ERR_OUT = WB_ERR_IN. ACK&ERR together treated as ERR.
- ACK/ERR with outstanding==0: ignored, no response, counter stays 0.
- CYC drops on the edge after final ACK/ERR when in DRAIN, outstanding becomes 0, STB=0 -> IDLE. ACTIVE with no commands keeps CYC high.
- Timeout: counter resets on any ACK/ERR or when outstanding==0; reaching TIMEOUT_CYCLES -> CYC/STB 0, outstanding and FIFO cleared, TIMEOUT_OUT pulses, -> IDLE; no RSP for lost beats.
- Reset mid-transfer: CYC/STB drop immediately; in-flight beats discarded.

Test Plan:
- Single write adr 0x100, sel 4'b1111, dat 0xDEADBEEF, LAST, slave ACKs next cycle -> one STB beat, CTI=3'b111, RSP_VALID with WE=1, DAT=0; CYC low 1 cycle after ACK.
- Read 0x104 with STALL high 3 cycles, ACK data 0x12345678 -> WB fields stable 4 cycles, RSP_DAT=0x12345678, WE=0.
- 6 back-to-back reads, slave withholds ACK -> exactly 4 beats issued, CMD_READY low until first ACK; all 6 responses in order.
- ACK on same cycle as new beat at outstanding=4 -> counter stays 4, no overflow, FIFO order intact.
- Write with ERR response -> RSP_ERR=1, CYC drops; following command starts new cycle.
- Read never acknowledged (TIMEOUT_CYCLES=8) -> TIMEOUT_OUT pulse 8 cycles after last beat, CYC=0, no RSP; reset asserted mid-burst clears all outputs asynchronously.

Source files
------------

// File: rtl/wb_master_cmd_bridge.sv
// Wishbone B4 pipelined master: turns a valid/ready command stream into
// WB beats, tracks in-flight addresses and returns one response per command.
module wb_master_cmd_bridge #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic        CLK,
    input  logic        RST_ASYNC_N,
    input  logic        CMD_VALID_IN,
    output logic        CMD_READY_OUT,
    input  logic [31:0] CMD_ADR_IN,
    input  logic        CMD_WE_IN,
    input  logic [3:0]  CMD_SEL_IN,
    input  logic [31:0] CMD_DAT_IN,
    input  logic        CMD_LAST_IN,
    output logic        RSP_VALID_OUT,
    output logic [31:0] RSP_DAT_OUT,
    output logic        RSP_WE_OUT,
    output logic        RSP_ERR_OUT,
    output logic        TIMEOUT_OUT,
    output logic [31:0] WB_ADR_OUT,
    output logic        WB_WE_OUT,
    output logic [3:0]  WB_SEL_OUT,
    output logic [31:0] WB_DAT_WR_OUT,
    output logic        WB_CYC_OUT,
    output logic        WB_STB_OUT,
    output logic [2:0]  WB_CTI_OUT,
    output logic [1:0]  WB_BTE_OUT,
    input  logic        WB_STALL_IN,
    input  logic        WB_ACK_IN,
    input  logic        WB_ERR_IN,
    input  logic [31:0] WB_DAT_RD_IN
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN
    } state_t;

    state_t                     r_state;
    logic [CW-1:0]              r_cnt;
    logic [MAX_OUTSTANDING-1:0] r_we_q;
    logic [TW-1:0]              r_to_cnt;

    logic                       w_beat;
    logic                       w_rsp;
    logic                       w_abort;
    logic                       w_room;
    logic                       w_acc;
    logic                       w_drain_done;
    logic [CW-1:0]              w_cnt_nxt;
    logic [CW-1:0]              w_push_idx;
    logic [MAX_OUTSTANDING-1:0] w_we_q_nxt;

    assign w_beat  = WB_STB_OUT & ~WB_STALL_IN;
    assign w_rsp   = (WB_ACK_IN | WB_ERR_IN) & (r_cnt != '0);
    assign w_abort = (r_cnt != '0) & ~(WB_ACK_IN | WB_ERR_IN)
                   & (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // The beat still held on STB counts against the in-flight budget.
    assign w_room = ({1'b0, r_cnt} + {{CW{1'b0}}, WB_STB_OUT})
                  < (CW + 1)'(MAX_OUTSTANDING);

    assign CMD_READY_OUT = (r_state != S_DRAIN)
                         & (~WB_STB_OUT | ~WB_STALL_IN)
                         & w_room & ~w_abort;

    assign w_acc      = CMD_VALID_IN & CMD_READY_OUT;
    assign w_cnt_nxt  = r_cnt + CW'(w_beat) - CW'(w_rsp);
    assign w_push_idx = r_cnt - CW'(w_rsp);

    assign w_drain_done = (r_state == S_DRAIN) & ~WB_STB_OUT
                        & (w_cnt_nxt == '0);

    assign WB_BTE_OUT = 2'b00;

    // WE history of in-flight beats; entry 0 is the oldest.
    always_comb begin
        w_we_q_nxt = w_rsp ? (r_we_q >> 1) : r_we_q;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (w_beat && (w_push_idx == CW'(i))) begin
                w_we_q_nxt[i] = WB_WE_OUT;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_we_q        <= '0;
            r_to_cnt      <= '0;
            RSP_VALID_OUT <= 1'b0;
            RSP_DAT_OUT   <= '0;
            RSP_WE_OUT    <= 1'b0;
            RSP_ERR_OUT   <= 1'b0;
            TIMEOUT_OUT   <= 1'b0;
            WB_ADR_OUT    <= '0;
            WB_WE_OUT     <= 1'b0;
            WB_SEL_OUT    <= '0;
            WB_DAT_WR_OUT <= '0;
            WB_CYC_OUT    <= 1'b0;
            WB_STB_OUT    <= 1'b0;
            WB_CTI_OUT    <= '0;
        end else begin
            RSP_VALID_OUT <= w_rsp;
            RSP_WE_OUT    <= w_rsp & r_we_q[0];
            RSP_ERR_OUT   <= w_rsp & WB_ERR_IN;
            RSP_DAT_OUT   <= (w_rsp & WB_ACK_IN & ~WB_ERR_IN & ~r_we_q[0])
                           ? WB_DAT_RD_IN : 32'h0;
            TIMEOUT_OUT   <= w_abort;

            if (w_abort) begin
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_we_q     <= '0;
                r_to_cnt   <= '0;
                WB_CYC_OUT <= 1'b0;
                WB_STB_OUT <= 1'b0;
            end else begin
                r_cnt  <= w_cnt_nxt;
                r_we_q <= w_we_q_nxt;
                if ((r_cnt == '0) || WB_ACK_IN || WB_ERR_IN) begin
                    r_to_cnt <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end

                if (w_acc) begin
                    WB_ADR_OUT    <= CMD_ADR_IN;
                    WB_WE_OUT     <= CMD_WE_IN;
                    WB_SEL_OUT    <= CMD_SEL_IN;
                    WB_DAT_WR_OUT <= CMD_DAT_IN;
                    WB_CTI_OUT    <= CMD_LAST_IN ? 3'b111 : 3'b010;
                    WB_STB_OUT    <= 1'b1;
                    WB_CYC_OUT    <= 1'b1;
                    r_state       <= CMD_LAST_IN ? S_DRAIN : S_ACTIVE;
                end else begin
                    if (w_beat) begin
                        WB_STB_OUT <= 1'b0;
                    end
                    if (w_drain_done) begin
                        WB_CYC_OUT <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_master_cmd_bridge.sv
// Bench for wb_master_cmd_bridge: directed vectors, corner sequences and
// randomized bursts scored against a command-level response model.
module tb_wb_master_cmd_bridge;

    localparam int MAXO = 4;
    localparam int TOC  = 8;

    logic        CLK = 1'b0;
    logic        RST_ASYNC_N = 1'b0;
    logic        CMD_VALID_IN = 1'b0;
    logic        CMD_READY_OUT;
    logic [31:0] CMD_ADR_IN = '0;
    logic        CMD_WE_IN = 1'b0;
    logic [3:0]  CMD_SEL_IN = '0;
    logic [31:0] CMD_DAT_IN = '0;
    logic        CMD_LAST_IN = 1'b0;
    logic        RSP_VALID_OUT;
    logic [31:0] RSP_DAT_OUT;
    logic        RSP_WE_OUT;
    logic        RSP_ERR_OUT;
    logic        TIMEOUT_OUT;
    logic [31:0] WB_ADR_OUT;
    logic        WB_WE_OUT;
    logic [3:0]  WB_SEL_OUT;
    logic [31:0] WB_DAT_WR_OUT;
    logic        WB_CYC_OUT;
    logic        WB_STB_OUT;
    logic [2:0]  WB_CTI_OUT;
    logic [1:0]  WB_BTE_OUT;
    logic        WB_STALL_IN = 1'b0;
    logic        WB_ACK_IN = 1'b0;
    logic        WB_ERR_IN = 1'b0;
    logic [31:0] WB_DAT_RD_IN = '0;

    int checks = 0;
    int errors = 0;

    wb_master_cmd_bridge #(
        .MAX_OUTSTANDING(MAXO),
        .TIMEOUT_CYCLES (TOC)
    ) dut (
        .CLK          (CLK),
        .RST_ASYNC_N  (RST_ASYNC_N),
        .CMD_VALID_IN (CMD_VALID_IN),
        .CMD_READY_OUT(CMD_READY_OUT),
        .CMD_ADR_IN   (CMD_ADR_IN),
        .CMD_WE_IN    (CMD_WE_IN),
        .CMD_SEL_IN   (CMD_SEL_IN),
        .CMD_DAT_IN   (CMD_DAT_IN),
        .CMD_LAST_IN  (CMD_LAST_IN),
        .RSP_VALID_OUT(RSP_VALID_OUT),
        .RSP_DAT_OUT  (RSP_DAT_OUT),
        .RSP_WE_OUT   (RSP_WE_OUT),
        .RSP_ERR_OUT  (RSP_ERR_OUT),
        .TIMEOUT_OUT  (TIMEOUT_OUT),
        .WB_ADR_OUT   (WB_ADR_OUT),
        .WB_WE_OUT    (WB_WE_OUT),
        .WB_SEL_OUT   (WB_SEL_OUT),
        .WB_DAT_WR_OUT(WB_DAT_WR_OUT),
        .WB_CYC_OUT   (WB_CYC_OUT),
        .WB_STB_OUT   (WB_STB_OUT),
        .WB_CTI_OUT   (WB_CTI_OUT),
        .WB_BTE_OUT   (WB_BTE_OUT),
        .WB_STALL_IN  (WB_STALL_IN),
        .WB_ACK_IN    (WB_ACK_IN),
        .WB_ERR_IN    (WB_ERR_IN),
        .WB_DAT_RD_IN (WB_DAT_RD_IN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          stall;
        int          ack_dly;
        logic        ack;
        logic        err;
        logic [31:0] rd;
        logic        exp_we;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vt[5];

    logic [31:0] c_adr[16];
    logic        c_we[16];
    logic [3:0]  c_sel[16];
    logic [31:0] c_dat[16];
    logic        c_err[16];
    logic        c_both[16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rdfun(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Entered and left at posedge+1.
    task automatic run_vec(input vec_t v, input string nm);
        CMD_VALID_IN = 1'b1;
        CMD_ADR_IN   = v.adr;
        CMD_WE_IN    = v.we;
        CMD_SEL_IN   = v.sel;
        CMD_DAT_IN   = v.dat;
        CMD_LAST_IN  = 1'b1;
        WB_STALL_IN  = (v.stall > 0);
        #1;
        chk({nm, "_ready"}, CMD_READY_OUT, 1);
        @(posedge CLK); #1;
        CMD_VALID_IN = 1'b0;
        CMD_LAST_IN  = 1'b0;
        chk({nm, "_stb"}, WB_STB_OUT, 1);
        chk({nm, "_cyc"}, WB_CYC_OUT, 1);
        chk({nm, "_adr"}, WB_ADR_OUT, v.adr);
        chk({nm, "_we"}, WB_WE_OUT, v.we);
        chk({nm, "_sel"}, WB_SEL_OUT, v.sel);
        chk({nm, "_dat"}, WB_DAT_WR_OUT, v.dat);
        chk({nm, "_cti"}, WB_CTI_OUT, 3'b111);
        chk({nm, "_bte"}, WB_BTE_OUT, 2'b00);
        for (int s = 0; s < v.stall; s++) begin
            @(posedge CLK); #1;
            chk({nm, "_stall_stb"}, WB_STB_OUT, 1);
            chk({nm, "_stall_adr"}, WB_ADR_OUT, v.adr);
        end
        WB_STALL_IN = 1'b0;
        @(posedge CLK); #1;
        chk({nm, "_stb_drop"}, WB_STB_OUT, 0);
        repeat (v.ack_dly) begin
            @(posedge CLK); #1;
        end
        WB_ACK_IN    = v.ack;
        WB_ERR_IN    = v.err;
        WB_DAT_RD_IN = v.rd;
        @(posedge CLK); #1;
        WB_ACK_IN = 1'b0;
        WB_ERR_IN = 1'b0;
        chk({nm, "_rsp_valid"}, RSP_VALID_OUT, 1);
        chk({nm, "_rsp_we"}, RSP_WE_OUT, v.exp_we);
        chk({nm, "_rsp_err"}, RSP_ERR_OUT, v.exp_err);
        chk({nm, "_rsp_dat"}, RSP_DAT_OUT, v.exp_dat);
        chk({nm, "_cyc_drop"}, WB_CYC_OUT, 0);
        @(posedge CLK); #1;
        chk({nm, "_rsp_pulse"}, RSP_VALID_OUT, 0);
    endtask

    // Streams c_*[0..n-1] as one WB cycle; the slave answers in order.
    task automatic run_stream(input int n, input int ack_start,
                              input int ack_pct, input int stall_pct,
                              input int valid_pct, input bit spur,
                              input string nm,
                              output int snap_beats, output logic snap_rdy,
                              output int max_infl);
        int cyc_n = 0;
        int cmd_i = 0;
        int beat_i = 0;
        int rsp_i = 0;
        int infl = 0;
        int wait_n = 0;
        int k;
        bit acc = 0;
        bit to_seen = 0;
        int pend[$];
        snap_beats = -1;
        snap_rdy   = 1'b1;
        max_infl   = 0;
        CMD_VALID_IN = 1'b0;
        while ((rsp_i < n || WB_CYC_OUT) && cyc_n < 400) begin
            if (RSP_VALID_OUT) begin
                if (rsp_i >= n) begin
                    checks++;
                    errors++;
                    $display("FAIL %s_rsp_extra actual=%0d required=%0d",
                             nm, rsp_i + 1, n);
                end else begin
                    chk({nm, "_rsp_we"}, RSP_WE_OUT, c_we[rsp_i]);
                    chk({nm, "_rsp_err"}, RSP_ERR_OUT, c_err[rsp_i]);
                    chk({nm, "_rsp_dat"}, RSP_DAT_OUT,
                        (c_we[rsp_i] || c_err[rsp_i]) ? 32'h0
                                                      : rdfun(c_adr[rsp_i]));
                    rsp_i++;
                end
            end
            if (TIMEOUT_OUT) to_seen = 1;

            WB_ACK_IN    = 1'b0;
            WB_ERR_IN    = 1'b0;
            WB_DAT_RD_IN = $urandom;
            if (pend.size() > 0 && cyc_n >= ack_start &&
                ($urandom_range(99) < ack_pct || wait_n >= 4)) begin
                k = pend.pop_front();
                WB_ERR_IN = c_err[k];
                WB_ACK_IN = !c_err[k] || c_both[k];
                if (!c_err[k] && !c_we[k]) WB_DAT_RD_IN = rdfun(c_adr[k]);
                infl--;
                wait_n = 0;
            end else if (pend.size() > 0) begin
                wait_n++;
            end else if (spur && $urandom_range(9) == 0) begin
                WB_ACK_IN = 1'b1;
            end

            WB_STALL_IN = ($urandom_range(99) < stall_pct);
            if (WB_STB_OUT && !WB_STALL_IN) begin
                if (beat_i >= n) begin
                    checks++;
                    errors++;
                    $display("FAIL %s_beat_extra actual=%0d required=%0d",
                             nm, beat_i + 1, n);
                end else begin
                    chk({nm, "_beat_adr"}, WB_ADR_OUT, c_adr[beat_i]);
                    chk({nm, "_beat_we"}, WB_WE_OUT, c_we[beat_i]);
                    chk({nm, "_beat_sel"}, WB_SEL_OUT, c_sel[beat_i]);
                    chk({nm, "_beat_dat"}, WB_DAT_WR_OUT, c_dat[beat_i]);
                    chk({nm, "_beat_cti"}, WB_CTI_OUT,
                        (beat_i == n - 1) ? 3'b111 : 3'b010);
                    pend.push_back(beat_i);
                    beat_i++;
                    infl++;
                    if (infl > max_infl) max_infl = infl;
                end
            end

            if (acc) CMD_VALID_IN = 1'b0;
            if (!CMD_VALID_IN && cmd_i < n &&
                $urandom_range(99) < valid_pct) begin
                CMD_ADR_IN   = c_adr[cmd_i];
                CMD_WE_IN    = c_we[cmd_i];
                CMD_SEL_IN   = c_sel[cmd_i];
                CMD_DAT_IN   = c_dat[cmd_i];
                CMD_LAST_IN  = (cmd_i == n - 1);
                CMD_VALID_IN = 1'b1;
            end
            #1;
            if (cyc_n == ack_start - 1) begin
                snap_beats = beat_i;
                snap_rdy   = CMD_READY_OUT;
            end
            acc = CMD_VALID_IN && CMD_READY_OUT;
            if (acc) cmd_i++;
            @(posedge CLK); #1;
            cyc_n++;
        end
        CMD_VALID_IN = 1'b0;
        CMD_LAST_IN  = 1'b0;
        WB_ACK_IN    = 1'b0;
        WB_ERR_IN    = 1'b0;
        WB_STALL_IN  = 1'b0;
        chk({nm, "_rsp_count"}, rsp_i, n);
        chk({nm, "_beat_count"}, beat_i, n);
        chk({nm, "_cyc_end"}, WB_CYC_OUT, 0);
        chk({nm, "_inflight_ok"}, (max_infl <= MAXO), 1);
        chk({nm, "_no_timeout"}, to_seen, 0);
    endtask

    initial begin
        int          sb;
        logic        sr;
        int          mi;
        int          to_at;
        int          n;
        bit          rsp_seen;

        vt[0] = '{1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 1'b1, 1'b0,
                  32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0};
        vt[1] = '{1'b0, 32'h104, 4'hF, 32'h0, 3, 0, 1'b1, 1'b0,
                  32'h12345678, 1'b0, 1'b0, 32'h12345678};
        vt[2] = '{1'b1, 32'h200, 4'h3, 32'h55, 0, 2, 1'b0, 1'b1,
                  32'hAAAA_5555, 1'b1, 1'b1, 32'h0};
        vt[3] = '{1'b0, 32'h300, 4'h1, 32'h0, 1, 1, 1'b1, 1'b1,
                  32'h0000_CAFE, 1'b0, 1'b1, 32'h0};
        vt[4] = '{1'b0, 32'h10C, 4'hC, 32'h0, 0, 3, 1'b1, 1'b0,
                  32'hA5A5_0F0F, 1'b0, 1'b0, 32'hA5A5_0F0F};

        #12;
        chk("rst_cyc", WB_CYC_OUT, 0);
        chk("rst_stb", WB_STB_OUT, 0);
        chk("rst_rsp", RSP_VALID_OUT, 0);
        chk("rst_to", TIMEOUT_OUT, 0);
        chk("rst_adr", WB_ADR_OUT, 0);
        chk("rst_cti", WB_CTI_OUT, 0);
        @(posedge CLK); #1;
        RST_ASYNC_N = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 5; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            c_adr[i]  = 32'h400 + 32'(i * 4);
            c_we[i]   = 1'b0;
            c_sel[i]  = 4'hF;
            c_dat[i]  = 32'h0;
            c_err[i]  = 1'b0;
            c_both[i] = 1'b0;
        end
        run_stream(6, 6, 100, 0, 100, 0, "b2b", sb, sr, mi);
        chk("b2b_beats_before_ack", sb, 4);
        chk("b2b_ready_before_ack", sr, 0);
        chk("b2b_max_inflight", mi, 4);

        CMD_VALID_IN = 1'b1;
        CMD_ADR_IN   = 32'h500;
        CMD_WE_IN    = 1'b0;
        CMD_SEL_IN   = 4'hF;
        CMD_LAST_IN  = 1'b1;
        @(posedge CLK); #1;
        CMD_VALID_IN = 1'b0;
        CMD_LAST_IN  = 1'b0;
        @(posedge CLK); #1;
        chk("to_beat_taken", WB_STB_OUT, 0);
        to_at = -1;
        rsp_seen = 0;
        for (int k = 1; k <= 20 && to_at < 0; k++) begin
            @(posedge CLK); #1;
            if (RSP_VALID_OUT) rsp_seen = 1;
            if (TIMEOUT_OUT) to_at = k;
        end
        chk("to_latency", to_at, TOC);
        chk("to_cyc", WB_CYC_OUT, 0);
        chk("to_stb", WB_STB_OUT, 0);
        chk("to_no_rsp", rsp_seen, 0);
        WB_ACK_IN = 1'b1;
        @(posedge CLK); #1;
        WB_ACK_IN = 1'b0;
        chk("to_pulse", TIMEOUT_OUT, 0);
        chk("late_ack_ignored", RSP_VALID_OUT, 0);
        @(posedge CLK); #1;

        CMD_VALID_IN = 1'b1;
        CMD_ADR_IN   = 32'h600;
        CMD_WE_IN    = 1'b1;
        CMD_DAT_IN   = 32'h1111_2222;
        CMD_LAST_IN  = 1'b0;
        repeat (3) @(posedge CLK);
        #3;
        RST_ASYNC_N = 1'b0;
        #1;
        chk("rstmid_cyc", WB_CYC_OUT, 0);
        chk("rstmid_stb", WB_STB_OUT, 0);
        chk("rstmid_adr", WB_ADR_OUT, 0);
        CMD_VALID_IN = 1'b0;
        @(posedge CLK); #1;
        RST_ASYNC_N = 1'b1;
        @(posedge CLK); #1;
        run_vec(vt[0], "post_rst");

        for (int b = 0; b < 12; b++) begin
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) begin
                c_adr[i]  = $urandom & 32'hFFFF_FFFC;
                c_we[i]   = 1'($urandom_range(1));
                c_sel[i]  = 4'($urandom_range(1, 15));
                c_dat[i]  = $urandom;
                c_err[i]  = ($urandom_range(9) == 0);
                c_both[i] = 1'($urandom_range(1));
            end
            run_stream(n, 0, $urandom_range(40, 100), $urandom_range(0, 60),
                       $urandom_range(30, 100), 1, $sformatf("rnd%0d", b),
                       sb, sr, mi);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
